// File: rtl/bsg_fpu_align_shift_pipe.sv
// Two-stage right-shift aligner: returns mantissa >> shamt plus guard/sticky.
// S1 captures the operand and its low-side OR-scan; S2 selects and registers results.
module bsg_fpu_align_shift_pipe #(
    parameter  int width_p    = 32,
    localparam int shamt_w_lp = $clog2(width_p) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic [width_p-1:0]    data_i,
    input  logic [shamt_w_lp-1:0] shamt_i,
    output logic                  v_o,
    input  logic                  yumi_i,
    output logic [width_p-1:0]    data_o,
    output logic                  guard_o,
    output logic                  sticky_o,
    output logic                  inexact_o
);

    typedef struct packed {
        logic [width_p-1:0]    data;
        logic [shamt_w_lp-1:0] shamt;
        logic [width_p-1:0]    scan;
    } s1_t;

    typedef struct packed {
        logic [width_p-1:0] data;
        logic               guard;
        logic               sticky;
    } s2_t;

    logic [2:1] vld_pipe;
    s1_t        s1_r, s1_n;
    s2_t        s2_r, s2_n;
    logic       adv1, adv2;

    assign adv2    = ~vld_pipe[2] | yumi_i;
    assign adv1    = ~vld_pipe[1] | adv2;
    assign ready_o = adv1;

    // scan[k] = |data_i[k:0]; sticky for shift s is then a single pick of scan[s-2]
    always_comb begin
        logic acc;
        acc        = 1'b0;
        s1_n.data  = data_i;
        s1_n.shamt = shamt_i;
        s1_n.scan  = '0;
        for (int k = 0; k < width_p; k++) begin
            acc          = acc | data_i[k];
            s1_n.scan[k] = acc;
        end
    end

    always_comb begin
        s2_n.data   = s1_r.data >> s1_r.shamt;
        s2_n.guard  = 1'b0;
        s2_n.sticky = 1'b0;
        for (int k = 0; k < width_p; k++) begin
            if (s1_r.shamt == shamt_w_lp'(k + 1)) s2_n.guard  = s1_r.data[k];
            if (s1_r.shamt == shamt_w_lp'(k + 2)) s2_n.sticky = s1_r.scan[k];
        end
        // everything shifted out past the guard collapses into sticky
        if (s1_r.shamt > shamt_w_lp'(width_p + 1)) s2_n.sticky = s1_r.scan[width_p-1];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_pipe <= '0;
            s1_r     <= '0;
            s2_r     <= '0;
        end else begin
            if (adv1) vld_pipe[1] <= v_i;
            if (adv2) vld_pipe[2] <= vld_pipe[1];
            if (adv1 & v_i)         s1_r <= s1_n;
            if (adv2 & vld_pipe[1]) s2_r <= s2_n;
        end
    end

    assign v_o       = vld_pipe[2];
    assign data_o    = vld_pipe[2] ? s2_r.data : '0;
    assign guard_o   = vld_pipe[2] & s2_r.guard;
    assign sticky_o  = vld_pipe[2] & s2_r.sticky;
    assign inexact_o = vld_pipe[2] & (s2_r.guard | s2_r.sticky);

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_fpu_align_shift_pipe.sv
// Directed checks for the aligner: vector table, streaming, stall and mid-stall reset.
module tb_bsg_fpu_align_shift_pipe;

    localparam int W  = 32;
    localparam int SW = $clog2(W) + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i, ready_o, v_o, yumi_i;
    logic [W-1:0]  data_i, data_o;
    logic [SW-1:0] shamt_i;
    logic          guard_o, sticky_o, inexact_o;

    int errors = 0;
    int checks = 0;

    bsg_fpu_align_shift_pipe #(.width_p(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .shamt_i(shamt_i), .v_o(v_o), .yumi_i(yumi_i),
        .data_o(data_o), .guard_o(guard_o), .sticky_o(sticky_o), .inexact_o(inexact_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic [W-1:0]  exp_d;
        logic          exp_g;
        logic          exp_s;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        int lat, first_vo, last_vo, got, sent, acc;
        logic [W-1:0] held;
        logic [W-1:0] sdata [8];
        logic seen;

        vecs[0]  = '{32'h000000FF, 6'd4,  32'h0000000F, 1'b1, 1'b1};
        vecs[1]  = '{32'h80000001, 6'd0,  32'h80000001, 1'b0, 1'b0};
        vecs[2]  = '{32'h80000001, 6'd32, 32'h00000000, 1'b1, 1'b1};
        vecs[3]  = '{32'h80000001, 6'd33, 32'h00000000, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000010, 6'd4,  32'h00000001, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000010, 6'd5,  32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 6'd1,  32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[7]  = '{32'h00000002, 6'd1,  32'h00000001, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000001, 6'd63, 32'h00000000, 1'b0, 1'b1};
        vecs[9]  = '{32'h00000000, 6'd40, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{32'hA5000000, 6'd24, 32'h000000A5, 1'b0, 1'b0};
        vecs[11] = '{32'h12345678, 6'd8,  32'h00123456, 1'b0, 1'b1};

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; shamt_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_v_o",     {31'b0, v_o},     32'd0);
        check("rst_ready_o", {31'b0, ready_o}, 32'd1);
        check("rst_data_o",  data_o,           32'd0);
        check("rst_flags",   {29'b0, guard_o, sticky_o, inexact_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // one item at a time through an otherwise empty pipe
        for (int i = 0; i < 12; i++) begin
            data_i = vecs[i].d; shamt_i = vecs[i].s; v_i = 1'b1;
            check($sformatf("v%0d_ready", i), {31'b0, ready_o}, 32'd1);
            @(negedge clk_i);
            v_i = 1'b0;
            lat = 1;
            while (!v_o && lat < 10) begin @(negedge clk_i); lat++; end
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_data", i), data_o, vecs[i].exp_d);
            check($sformatf("v%0d_guard", i), {31'b0, guard_o}, {31'b0, vecs[i].exp_g});
            check($sformatf("v%0d_sticky", i), {31'b0, sticky_o}, {31'b0, vecs[i].exp_s});
            check($sformatf("v%0d_inexact", i), {31'b0, inexact_o},
                  {31'b0, vecs[i].exp_g | vecs[i].exp_s});
            yumi_i = v_o;
            @(negedge clk_i);
            yumi_i = 1'b0;
            check($sformatf("v%0d_drained", i), {31'b0, v_o}, 32'd0);
        end

        // back-to-back stream with an always-taking consumer
        for (int k = 0; k < 8; k++) sdata[k] = 32'hF0F0F0F0 + k * 32'h01010101;
        sent = 0; got = 0; first_vo = -1; last_vo = -1; acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (v_o) begin
                if (got < 8) check($sformatf("stream_out%0d", got), data_o, sdata[got] >> got);
                if (first_vo < 0) first_vo = c;
                last_vo = c;
                got++;
            end
            yumi_i = v_o;
            if (sent < 8) begin
                #1;
                if (!ready_o) acc++;
                v_i = 1'b1; data_i = sdata[sent]; shamt_i = SW'(sent);
                sent++;
            end else v_i = 1'b0;
            @(negedge clk_i);
        end
        yumi_i = 1'b0;
        check("stream_count",      got,            8);
        check("stream_first_lat",  first_vo,       2);
        check("stream_contiguous", last_vo - first_vo, 7);
        check("stream_ready_drop", acc,            0);

        // stall: consumer holds off, producer keeps offering
        acc = 0; seen = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            v_i = 1'b1; data_i = 32'h00000100 << acc; shamt_i = 6'd8;
            if (ready_o) acc++;
            if (v_o && !seen) begin held = data_o; seen = 1'b1; end
            else if (v_o) check($sformatf("stall_hold%0d", c), data_o, held);
            @(negedge clk_i);
        end
        check("stall_accepts", acc,               2);
        check("stall_ready",   {31'b0, ready_o},  32'd0);
        check("stall_v_o",     {31'b0, v_o},      32'd1);
        check("stall_head",    data_o,            32'h00000001);

        // reset in the middle of the stall acts without a clock edge
        reset_i = 1'b1;
        #1;
        check("async_rst_v_o",   {31'b0, v_o},     32'd0);
        check("async_rst_ready", {31'b0, ready_o}, 32'd1);
        check("async_rst_data",  data_o,           32'd0);
        v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (v_o) acc++;
        end
        check("no_stale_after_rst", acc,              0);
        check("ready_after_rst",    {31'b0, ready_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
